// File: rtl/fifo_rr_burst_arb.sv
// fifo_rr_burst_arb
//   Round-robin burst read scheduler for CH_NUM prefetch (FWFT) FIFOs.
//   One channel is granted at a time. Up to BURST_LEN words are drained from it
//   into a single registered output stream. Each output word is tagged with its
//   channel index and with an end-of-burst flag.
//
// Ports
//   clk, rst      single clock, synchronous active-high reset
//   arb_en        1: new bursts may start; 0: finish the current burst, then stay idle
//   ch_rd_vld     per-FIFO head-word valid
//   ch_rd_data    per-FIFO head word, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ch_rd_en      per-FIFO pop (combinational, at most one bit set)
//   out_data      registered output word
//   out_ch        channel index of out_data
//   out_last      out_data is the BURST_LEN-th word of its burst
//   out_valid     out_data/out_ch/out_last are valid
//   out_ready     downstream accept
//   grant_ch      currently or most recently granted channel
//   busy          high while a burst is in progress (mirrors the FSM state)
//   burst_abort   one-cycle pulse after a burst is cut short by a stall timeout
//
// Handshake: a word moves downstream on every clock edge where
// out_valid & out_ready are both high. out_data/out_ch/out_last hold while
// out_valid & ~out_ready. A FIFO word is popped on an edge where ch_rd_en[i]
// is high, and ch_rd_en[i] is only driven while ch_rd_vld[i] is high.

module fifo_rr_burst_arb #(
  parameter int CH_NUM     = 4,
  parameter int DATA_WIDTH = 24,
  parameter int BURST_LEN  = 64,
  parameter int STALL_MAX  = 16,
  localparam int CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arb_en,
  input  logic [CH_NUM-1:0]            ch_rd_vld,
  input  logic [CH_NUM*DATA_WIDTH-1:0] ch_rd_data,
  output logic [CH_NUM-1:0]            ch_rd_en,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CH_W-1:0]              grant_ch,
  output logic                         busy,
  output logic                         burst_abort
);

  localparam int SW = $clog2(STALL_MAX + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CH_W-1:0] rr_ptr;
  logic [CNT_W-1:0] burst_cnt;
  logic [SW-1:0]   stall_cnt;

  logic            arb_hit;
  logic [CH_W-1:0] arb_sel;
  logic            g_vld;
  logic [DATA_WIDTH-1:0] g_data;
  logic            pop;
  logic            burst_done;
  logic            stall_hit;
  logic            start_burst;

  // Search order starts one past the last grant and wraps, so the previously
  // served channel is considered last.
  always_comb begin
    int cand;
    logic [CH_W-1:0] cand_idx;
    arb_hit  = 1'b0;
    arb_sel  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= CH_NUM; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= CH_NUM) cand = cand - CH_NUM;
      cand_idx = CH_W'(cand);
      if (!arb_hit && ch_rd_vld[cand_idx]) begin
        arb_hit = 1'b1;
        arb_sel = cand_idx;
      end
    end
  end

  always_comb begin
    g_vld       = ch_rd_vld[grant_ch];
    g_data      = ch_rd_data[grant_ch*DATA_WIDTH +: DATA_WIDTH];
    // Pop only when the output register is empty or is being emptied this cycle.
    pop         = (state_q == ST_BURST) && g_vld && (!out_valid || out_ready);
    burst_done  = pop && (burst_cnt == CNT_W'(BURST_LEN - 1));
    // Backpressure with data present is not a stall; only an empty head counts.
    stall_hit   = (state_q == ST_BURST) && !g_vld && (stall_cnt == SW'(STALL_MAX - 1));
    start_burst = (state_q == ST_IDLE) && arb_en && arb_hit;
    ch_rd_en    = '0;
    if (pop) ch_rd_en[grant_ch] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_burst) state_d = ST_BURST;
      ST_BURST: if (burst_done || stall_hit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr      <= CH_W'(CH_NUM - 1);
      grant_ch    <= '0;
      burst_cnt   <= '0;
      stall_cnt   <= '0;
      out_data    <= '0;
      out_ch      <= '0;
      out_last    <= 1'b0;
      out_valid   <= 1'b0;
      burst_abort <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_abort <= stall_hit;

      if (start_burst) begin
        grant_ch  <= arb_sel;
        rr_ptr    <= arb_sel;
        burst_cnt <= '0;
        stall_cnt <= '0;
      end

      if (pop) begin
        out_data  <= g_data;
        out_ch    <= grant_ch;
        out_valid <= 1'b1;
        out_last  <= (burst_cnt == CNT_W'(BURST_LEN - 1));
        burst_cnt <= burst_done ? '0 : burst_cnt + 1'b1;
        stall_cnt <= '0;
      end else begin
        if (out_valid && out_ready) out_valid <= 1'b0;
        if ((state_q == ST_BURST) && !g_vld && (stall_cnt != SW'(STALL_MAX)))
          stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign busy = (state_q == ST_BURST);

endmodule

// File: tb/tb_fifo_rr_burst_arb.sv
// Testbench for fifo_rr_burst_arb.
//   dut   : CH_NUM=4, BURST_LEN=4, STALL_MAX=4 (scenarios 1-4 and 6)
//   dut8  : CH_NUM=4, BURST_LEN=8, STALL_MAX=4 (arb_en drop mid-burst)
// FIFOs are modelled as per-channel queues with FWFT behaviour. Inputs change
// 1 time unit after the rising edge; outputs are sampled on the falling edge.

module tb_fifo_rr_burst_arb;

  localparam int CH  = 4;
  localparam int DW  = 24;
  localparam int BL  = 4;
  localparam int SM  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            arb_en;
  logic [CH-1:0]   ch_rd_vld;
  logic [CH*DW-1:0] ch_rd_data;
  logic [CH-1:0]   ch_rd_en;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_ch;
  logic            out_last;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      grant_ch;
  logic            busy;
  logic            burst_abort;

  logic            arb_en8;
  logic [CH-1:0]   vld8;
  logic [DW-1:0]   seq8;
  logic [CH*DW-1:0] data8;
  logic [CH-1:0]   en8;
  logic [DW-1:0]   o8_data;
  logic [1:0]      o8_ch;
  logic            o8_last;
  logic            o8_valid;
  logic            o8_ready;
  logic [1:0]      grant8;
  logic            busy8;
  logic            abort8;

  assign data8 = {72'd0, seq8};

  always #5 clk = ~clk;

  fifo_rr_burst_arb #(.CH_NUM(CH), .DATA_WIDTH(DW), .BURST_LEN(BL), .STALL_MAX(SM)) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en), .ch_rd_vld(ch_rd_vld), .ch_rd_data(ch_rd_data),
    .ch_rd_en(ch_rd_en), .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .grant_ch(grant_ch), .busy(busy),
    .burst_abort(burst_abort)
  );

  fifo_rr_burst_arb #(.CH_NUM(CH), .DATA_WIDTH(DW), .BURST_LEN(8), .STALL_MAX(SM)) dut8 (
    .clk(clk), .rst(rst), .arb_en(arb_en8), .ch_rd_vld(vld8), .ch_rd_data(data8),
    .ch_rd_en(en8), .out_data(o8_data), .out_ch(o8_ch), .out_last(o8_last),
    .out_valid(o8_valid), .out_ready(o8_ready), .grant_ch(grant8), .busy(busy8),
    .burst_abort(abort8)
  );

  // Scoreboard and bookkeeping
  logic [31:0] exp_q[$];
  logic [23:0] fq[4][$];
  int          acc_cyc[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          acc_cnt  = 0;
  int          abort_cnt = 0;
  int          abort_cyc = 0;
  int          held_cnt = 0;
  int          acc8     = 0;
  int          last8_cnt = 0;
  logic        held_prev = 1'b0;
  logic [31:0] held_word = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [23:0] wdata(input int c, input int n);
    return 24'hA00000 | 24'(c << 12) | 24'(n);
  endfunction

  function automatic logic [31:0] mk(input logic last, input int c, input int n);
    return {5'd0, last, 2'(c), wdata(c, n)};
  endfunction

  task automatic refresh();
    for (int c = 0; c < CH; c++) begin
      ch_rd_vld[c] = (fq[c].size() > 0);
      ch_rd_data[c*DW +: DW] = (fq[c].size() > 0) ? fq[c][0] : 24'd0;
    end
  endtask

  task automatic load(input int c, input int n0, input int cnt);
    for (int k = 0; k < cnt; k++) fq[c].push_back(wdata(c, n0 + k));
    refresh();
  endtask

  task automatic expect_words(input int c, input int n0, input int cnt);
    for (int k = 0; k < cnt; k++) exp_q.push_back(mk(((n0 + k) % BL) == BL - 1, c, n0 + k));
  endtask

  // One clock: sample/score on the falling edge, then update the FIFO models
  // just after the rising edge using the pops sampled before it.
  task automatic tick();
    logic [31:0]   w;
    logic [CH-1:0] en_s;
    logic [CH-1:0] en8_s;
    @(negedge clk);
    w = {5'd0, out_last, out_ch, out_data};
    if (held_prev) check("hold_stable", w, held_word);
    if (out_valid && !out_ready) begin
      held_cnt++;
      check("pop_while_held", {31'd0, |ch_rd_en}, 32'd0);
    end
    if (ch_rd_en != '0) check("pop_onehot", $countones(ch_rd_en), 32'd1);
    held_prev = out_valid && !out_ready && !rst;
    held_word = w;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("extra_word", w, 32'hFFFF_FFFF);
      else check("word", w, exp_q.pop_front());
      acc_cyc.push_back(cyc);
      acc_cnt++;
    end
    if (burst_abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    if (o8_valid && o8_ready) begin
      check("t5_data", {8'd0, o8_data}, 32'(acc8));
      check("t5_last", {31'd0, o8_last}, {31'd0, acc8 == 7});
      if (o8_last) last8_cnt++;
      acc8++;
    end
    en_s  = ch_rd_en;
    en8_s = en8;
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < CH; c++)
      if (en_s[c] && fq[c].size() > 0) void'(fq[c].pop_front());
    if (en8_s[0]) seq8 = seq8 + 1'b1;
    refresh();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    arb_en = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < CH; c++) fq[c].delete();
    refresh();
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    acc_cyc.delete();
    acc_cnt = 0;
    abort_cnt = 0;
    held_cnt = 0;
  endtask

  task automatic run_words(input string tag, input int n, input int budget);
    int b = 0;
    while (acc_cnt < n && b < budget) begin
      tick();
      b++;
    end
    check(tag, acc_cnt, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int busy8_cnt;
    arb_en8 = 1'b0;
    vld8 = '0;
    seq8 = '0;
    o8_ready = 1'b1;
    ch_rd_vld = '0;
    ch_rd_data = '0;

    // Reset state
    do_reset();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {8'd0, out_data}, 32'd0);
    check("rst_out_ch_last", {29'd0, out_ch, out_last}, 32'd0);
    check("rst_grant", {30'd0, grant_ch}, 32'd0);
    check("rst_busy_abort", {30'd0, busy, burst_abort}, 32'd0);
    check("rst_rd_en", {28'd0, ch_rd_en}, 32'd0);

    // 1: all channels valid -> grants 0,1,2,3,0, one idle cycle between bursts
    do_reset();
    for (int c = 0; c < CH; c++) load(c, 0, 8);
    for (int c = 0; c < CH; c++) expect_words(c, 0, 4);
    expect_words(0, 4, 4);
    arb_en = 1'b1;
    out_ready = 1'b1;
    run_words("t1_words", 20, 200);
    for (int k = 1; k < 20 && k < acc_cyc.size(); k++)
      check("t1_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), (k % 4 == 0) ? 32'd2 : 32'd1);
    check("t1_exp_empty", exp_q.size(), 32'd0);

    // 2: only ch2, 10 words -> 4,4,2 then stall abort
    do_reset();
    load(2, 0, 10);
    expect_words(2, 0, 10);
    arb_en = 1'b1;
    out_ready = 1'b1;
    run_words("t2_words", 10, 200);
    b = 0;
    while (abort_cnt == 0 && b < 40) begin
      tick();
      b++;
    end
    for (int k = 0; k < 3; k++) tick();
    check("t2_abort_pulses", abort_cnt, 32'd1);
    if (acc_cyc.size() >= 10) check("t2_abort_delay", 32'(abort_cyc - acc_cyc[9]), 32'(SM));
    check("t2_busy_after", {31'd0, busy}, 32'd0);
    check("t2_exp_empty", exp_q.size(), 32'd0);

    // 3: out_ready toggling during a burst
    do_reset();
    load(0, 0, 4);
    expect_words(0, 0, 4);
    arb_en = 1'b1;
    b = 0;
    while (acc_cnt < 4 && b < 40) begin
      out_ready = b[0] ? 1'b0 : 1'b1;
      tick();
      b++;
    end
    check("t3_words", acc_cnt, 32'd4);
    check("t3_backpressure_seen", {31'd0, held_cnt > 0}, 32'd1);
    check("t3_exp_empty", exp_q.size(), 32'd0);
    check("t3_fifo_drained", fq[0].size(), 32'd0);

    // 4: rr pointer on ch1, ch1 and ch3 pending -> ch3 before ch1
    do_reset();
    load(1, 0, 4);
    expect_words(1, 0, 4);
    arb_en = 1'b1;
    out_ready = 1'b1;
    run_words("t4_first", 4, 100);
    for (int k = 0; k < 3; k++) tick();
    arb_en = 1'b0;
    load(1, 4, 4);
    load(3, 0, 4);
    tick();
    check("t4_idle_when_disabled", {31'd0, busy}, 32'd0);
    expect_words(3, 0, 4);
    expect_words(1, 4, 4);
    arb_en = 1'b1;
    acc_cnt = 0;
    run_words("t4_words", 8, 100);
    check("t4_exp_empty", exp_q.size(), 32'd0);

    // 5: arb_en dropped at word 2 of an 8-word burst
    do_reset();
    vld8 = 4'b0001;
    seq8 = '0;
    acc8 = 0;
    last8_cnt = 0;
    arb_en8 = 1'b1;
    b = 0;
    while (acc8 < 2 && b < 40) begin
      tick();
      b++;
    end
    arb_en8 = 1'b0;
    while (acc8 < 8 && b < 80) begin
      tick();
      b++;
    end
    busy8_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (busy8 || o8_valid) busy8_cnt++;
    end
    check("t5_words", acc8, 32'd8);
    check("t5_last_count", last8_cnt, 32'd1);
    check("t5_stays_idle", busy8_cnt, 32'd0);
    check("t5_busy", {31'd0, busy8}, 32'd0);
    vld8 = '0;

    // 6: reset in the middle of a burst with a word in the output register
    do_reset();
    for (int c = 0; c < CH; c++) load(c, 0, 8);
    expect_words(0, 0, 4);
    arb_en = 1'b1;
    out_ready = 1'b1;
    run_words("t6_pre", 1, 20);
    check("t6_valid_at_rst", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    check("t6_out_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rd_en", {28'd0, ch_rd_en}, 32'd0);
    check("t6_grant", {30'd0, grant_ch}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < CH; c++) fq[c].delete();
    exp_q.delete();
    acc_cnt = 0;
    for (int c = 0; c < CH; c++) load(c, 0, 8);
    expect_words(0, 0, 4);
    out_ready = 1'b1;
    run_words("t6_restart", 4, 50);
    check("t6_exp_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
